param_event_counter: RTL

- Parametrised successor to the fixed 4-bit counter: WIDTH-bit up/down event counter with a programmable terminal value and three terminal modes (wrap, saturate, one-shot).
- Sticky overflow/underflow flags, a one-cycle terminal-count pulse, and a synchronous load.
- Used for event and timeout counting in control blocks; all outputs registered.

---
 rtl/param_event_counter_pkg.sv | 14 +
 rtl/event_prescaler.sv | 30 +++
 rtl/param_event_counter.sv | 102 ++++++++++
 3 files changed

// File: rtl/param_event_counter_pkg.sv
// param_event_counter_pkg: shared mode encodings and FSM state type for the event counter
//   Ports: none (package only)
package param_event_counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

endpackage

// File: rtl/event_prescaler.sv
// event_prescaler: divides enabled cycles so only every PRESCALE-th one produces a tick
//   clk      : clock, rising edge
//   reset    : synchronous active-high reset, phase returns to 0
//   i_clr    : synchronous phase restart (driven by counter load)
//   i_enable : counts one enabled cycle; phase holds while low
//   o_tick   : high in the cycle that completes a PRESCALE-cycle group
module event_prescaler #(
    parameter int PRESCALE = 4
)(
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_enable,
    output logic o_tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] r_cnt;

    assign o_tick = i_enable && (r_cnt == PW'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (reset || i_clr)
            r_cnt <= '0;
        else if (i_enable)
            r_cnt <= o_tick ? '0 : r_cnt + PW'(1);
    end

endmodule

// File: rtl/param_event_counter.sv
// param_event_counter: WIDTH-bit up/down event counter with wrap/saturate/one-shot terminal modes
//   Optional macro PARAM_EVENT_COUNTER_PRESCALE_EN adds parameter PRESCALE and a step divider.
//   clk, reset    : clock and synchronous active-high reset
//   enable, up_dn : step request and direction (1 = up)
//   mode          : 00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
//   max_val       : up terminal value / down wrap target
//   load,load_val : synchronous load (beats stepping, leaves DONE)
//   start         : re-arms one-shot from DONE
//   flag_clr      : clears sticky flags (a same-cycle set wins)
//   count_out, tc_pulse, overflow_out, underflow_out, done_out : registered outputs
module param_event_counter
    import param_event_counter_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
`ifdef PARAM_EVENT_COUNTER_PRESCALE_EN
    ,
    parameter int              PRESCALE  = 4
`endif
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_dn,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] max_val,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] count_out,
    output logic             tc_pulse,
    output logic             overflow_out,
    output logic             underflow_out,
    output logic             done_out
);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_count, w_count_nxt;
    logic             r_tc, r_ovf, r_udf;
    logic             w_tick, w_step, w_term, w_wrap;

`ifdef PARAM_EVENT_COUNTER_PRESCALE_EN
    event_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (load),
        .i_enable (enable),
        .o_tick   (w_tick)
    );
`else
    assign w_tick = 1'b1;
`endif

    // load outranks stepping, so a step is only taken when no load is pending
    assign w_step = (r_state == ST_RUN) && enable && w_tick && !load;
    // >= so a count left above a lowered max_val still terminates instead of running away
    assign w_term = up_dn ? (r_count >= max_val) : (r_count == '0);
    // the reserved mode encoding behaves as wrap
    assign w_wrap = (mode != MODE_SAT) && (mode != MODE_ONESHOT);

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        if (load) begin
            w_count_nxt = load_val;
            w_state_nxt = ST_RUN;
        end else if (r_state == ST_DONE) begin
            // leaving one-shot mode also releases DONE
            w_state_nxt = (start || mode != MODE_ONESHOT) ? ST_RUN : ST_DONE;
        end else if (w_step) begin
            if (!w_term)
                w_count_nxt = up_dn ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
            else if (w_wrap)
                w_count_nxt = up_dn ? '0 : max_val;
            w_state_nxt = (w_term && mode == MODE_ONESHOT) ? ST_DONE : ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_count <= RESET_VAL;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_tc    <= w_step && w_term;
            r_ovf   <= (w_step && w_term && up_dn) || (r_ovf && !flag_clr);
            r_udf   <= (w_step && w_term && !up_dn) || (r_udf && !flag_clr);
        end
    end

    assign count_out     = r_count;
    assign tc_pulse      = r_tc;
    assign overflow_out  = r_ovf;
    assign underflow_out = r_udf;
    assign done_out      = (r_state == ST_DONE);

endmodule
